// File: rtl/ip4_axi_slv.sv
// AXI4 slave bridging bursts onto a single-port req/gnt memory with a write-response FIFO.
// Define IP4_AXI_SLV_WRAP_EN to support WRAP bursts; otherwise WRAP returns SLVERR.
module ip4_axi_slv #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OUTST  = 4
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(OUTST);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [2:0]  SIZE_MAX = 3'($clog2(STRB_W));

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_DATA = 2'd3;

`ifdef IP4_AXI_SLV_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
    logic wrap_ok;
    wrap_ok = WRAP_EN && ((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
    return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
  endfunction

  // WRAP keeps the upper bits of the (len+1)<<size window and wraps the incremented low bits.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] burst,
                                                  input logic [3:0] len,
                                                  input logic [2:0] size);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    inc  = a + step;
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  logic [1:0]        w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [3:0]        w_len_q, w_len_d;
  logic [2:0]        w_size_q, w_size_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic [3:0]        w_beat_q, w_beat_d;
  logic              w_err_q, w_err_d;
  logic              w_bad_burst_q, w_bad_burst_d;
  logic              w_bad_size_q, w_bad_size_d;

  logic [1:0]        r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [3:0]        r_len_q, r_len_d;
  logic [2:0]        r_size_q, r_size_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [3:0]        r_beat_q, r_beat_d;
  logic              r_bad_q, r_bad_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              rr_q, rr_d;
  logic [ID_W+1:0]   fifo_q [OUTST];
  logic [ID_W+1:0]   fifo_d [OUTST];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic w_want, r_want, w_sel, r_sel;
  logic wready_c, rvalid_c;
  logic fifo_full, fifo_push, fifo_pop;

  // rr_q set means the read side wins the next contended cycle.
  always_comb begin
    w_want = (w_state_q == W_DATA) && wvalid && !w_bad_burst_q;
    r_want = (r_state_q == R_REQ) && !r_bad_q;
    w_sel  = w_want && (!r_want || !rr_q);
    r_sel  = r_want && !w_sel;
    rr_d   = rr_q;
    if (mem_gnt && w_sel) rr_d = 1'b1;
    if (mem_gnt && r_sel) rr_d = 1'b0;
  end

  always_comb begin
    w_state_d     = w_state_q;
    w_id_d        = w_id_q;
    w_addr_d      = w_addr_q;
    w_len_d       = w_len_q;
    w_size_d      = w_size_q;
    w_burst_d     = w_burst_q;
    w_beat_d      = w_beat_q;
    w_err_d       = w_err_q;
    w_bad_burst_d = w_bad_burst_q;
    w_bad_size_d  = w_bad_size_q;
    wready_c      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && !fifo_full) begin
          w_id_d        = awid;
          w_addr_d      = awaddr;
          w_len_d       = awlen;
          w_size_d      = awsize;
          w_burst_d     = awburst;
          w_beat_d      = '0;
          w_bad_burst_d = burst_bad(awburst, awlen);
          w_bad_size_d  = awsize > SIZE_MAX;
          w_err_d       = burst_bad(awburst, awlen) || (awsize > SIZE_MAX);
          w_state_d     = W_DATA;
        end
      end
      W_DATA: begin
        // Unsupported burst types drain beats without touching memory.
        wready_c = w_bad_burst_q ? 1'b1 : (w_sel && mem_gnt);
        if (wvalid && wready_c) begin
          if (wlast != (w_beat_q == w_len_q)) w_err_d = 1'b1;
          if (w_beat_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_beat_d = w_beat_q + 4'd1;
            w_addr_d = next_addr(w_addr_q, w_burst_q, w_len_q, w_size_q);
          end
        end
      end
      W_RESP:  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_bad_d   = r_bad_q;
    rdata_d   = rdata_q;
    rvalid_c  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_id_d    = arid;
          r_addr_d  = araddr;
          r_len_d   = arlen;
          r_size_d  = arsize;
          r_burst_d = arburst;
          r_beat_d  = '0;
          r_bad_d   = burst_bad(arburst, arlen) || (arsize > SIZE_MAX);
          r_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (r_bad_q) begin
          rdata_d   = '0;
          r_state_d = R_DATA;
        end else if (r_sel && mem_gnt) begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT, R_DATA: begin
        // R_WAIT presents mem_rdata directly; it is only registered if the beat stalls.
        rvalid_c = 1'b1;
        if (r_state_q == R_WAIT) rdata_d = mem_rdata;
        if (rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_beat_d  = r_beat_q + 4'd1;
            r_addr_d  = next_addr(r_addr_q, r_burst_q, r_len_q, r_size_q);
            r_state_d = R_REQ;
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    fifo_full = cnt_q == CNT_W'(OUTST);
    fifo_push = w_state_q == W_RESP;
    fifo_pop  = (cnt_q != '0) && bready;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (fifo_push) begin
      fifo_d[wr_ptr_q] = {w_id_q, (w_err_q ? RESP_SLVERR : RESP_OKAY)};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rr_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
    w_id_q        <= w_id_d;
    w_addr_q      <= w_addr_d;
    w_len_q       <= w_len_d;
    w_size_q      <= w_size_d;
    w_burst_q     <= w_burst_d;
    w_beat_q      <= w_beat_d;
    w_err_q       <= w_err_d;
    w_bad_burst_q <= w_bad_burst_d;
    w_bad_size_q  <= w_bad_size_d;
    r_id_q        <= r_id_d;
    r_addr_q      <= r_addr_d;
    r_len_q       <= r_len_d;
    r_size_q      <= r_size_d;
    r_burst_q     <= r_burst_d;
    r_beat_q      <= r_beat_d;
    r_bad_q       <= r_bad_d;
    rdata_q       <= rdata_d;
    fifo_q        <= fifo_d;
  end

  assign awready   = !rst && (w_state_q == W_IDLE) && !fifo_full;
  assign wready    = !rst && wready_c;
  assign bvalid    = !rst && (cnt_q != '0);
  assign bid       = fifo_q[rd_ptr_q][ID_W+1:2];
  assign bresp     = rst ? 2'b00 : fifo_q[rd_ptr_q][1:0];
  assign arready   = !rst && (r_state_q == R_IDLE);
  assign rvalid    = !rst && rvalid_c;
  assign rid       = r_id_q;
  assign rdata     = (r_state_q == R_WAIT) ? mem_rdata : rdata_q;
  assign rresp     = (!rst && rvalid_c && r_bad_q) ? RESP_SLVERR : RESP_OKAY;
  assign rlast     = !rst && rvalid_c && (r_beat_q == r_len_q);
  assign mem_req   = !rst && (w_sel || r_sel);
  assign mem_we    = !rst && w_sel;
  assign mem_addr  = w_sel ? w_addr_q : r_addr_q;
  assign mem_wdata = wdata;
  assign mem_wstrb = (!rst && w_sel && !w_bad_size_q) ? wstrb : '0;

endmodule
